f1_reaction_timer: RTL and testbench
====================================

Name: f1_reaction_timer

Overview:
- Downstream consumer of the F1 start-light sequencer output (8-bit lights bus, one LED added per tick).
- Watches the bus for the all-on to all-off transition ("lights out"), then counts millisecond ticks until the driver button is pressed.
- Reports the reaction time, or a jump start if the button is pressed before lights out.
- Feeds the 7-seg/display stage.

Parameters:
- CNT_WIDTH, 16, width of reaction-time counter and result.
- MAX_MS, 9999, timeout in ms ticks; counter saturates here.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- lights  input  8  light pattern from start-light FSM.
- ms_tick  input  1  single-cycle 1 kHz enable from a clktick divider.
- btn  input  1  raw driver button, asynchronous to clk.
- react_time  output  CNT_WIDTH  last measured time in ms, held until next result.
- valid  output  1  one-cycle pulse when react_time updates.
- jump_start  output  1  level; high in FOUL state.
- timeout  output  1  level; high when last result saturated at MAX_MS.
- busy  output  1  high in ARMED, WAIT_OUT or TIMING.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - react_time=0, valid=0, jump_start=0, timeout=0, busy=0.
  - Internal counter=0, synchroniser flops=0.
- Button path:
  - btn passes through 2-flop synchroniser, then rising-edge detect: press = s2 & ~s3.
  - press is asserted 3 clk cycles after btn rises (worst case).
  - Only rising edges count; a held button never re-triggers.
- States and transitions:
  - IDLE: lights==8'h01 -> ARMED.
  - ARMED (sequence building): press -> FOUL; lights==8'hFF -> WAIT_OUT.
  - WAIT_OUT: press -> FOUL; lights==8'h00 -> TIMING, counter cleared to 0.
  - TIMING:
    - ms_tick increments counter (saturating at MAX_MS).
    - press -> DONE: react_time<=counter, valid=1 for one cycle, timeout<=0.
    - counter==MAX_MS with no press -> DONE: react_time<=MAX_MS, valid pulse, timeout<=1.
  - DONE: lights==8'h01 -> ARMED (new sequence). timeout and react_time hold.
  - FOUL: jump_start=1; react_time unchanged; lights==8'h01 -> ARMED, clearing jump_start.
- Simultaneous events:
  - press and ms_tick in the same TIMING cycle: the tick is not counted; result = counter before increment.
  - press in WAIT_OUT in the same cycle lights==8'h00: FOUL wins (press precedes lights out).
- Counter arithmetic: unsigned, CNT_WIDTH bits; MAX_MS must fit (elaboration assertion).
- Irregular lights: patterns other than the listed values cause no transition. Lights dropping to 0 from ARMED (before all-on) returns to IDLE.
- Reset mid-operation: immediate return to reset values; no valid pulse.

Optional Feature:
- Macro: F1_REACT_BEST_EN.
- Defined:
  - Adds output best_time [CNT_WIDTH-1:0], reset to MAX_MS.
  - On each valid pulse with timeout=0 and react_time < best_time, best_time updates on the same edge as react_time.
  - FOUL and timeout results never update best_time.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Package f1_react_pkg:
  - State enum typedef (IDLE, ARMED, WAIT_OUT, TIMING, DONE, FOUL).
  - Constants LIGHTS_FIRST=8'h01, LIGHTS_ALL=8'hFF, LIGHTS_OFF=8'h00.
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, async active-high reset, output press.

Test Plan:
- Normal run: lights 01,03,…,FF,00; btn rises after 237 ms_ticks -> valid pulse once, react_time=237, jump_start=0, timeout=0.
- Jump start: btn rises while lights=8'h0F -> FOUL, jump_start=1, no valid. Next lights=8'h01 -> jump_start=0, busy=1.
- Timeout: lights out, no press, MAX_MS=50 -> after 50 ticks valid pulses, react_time=50, timeout=1.
- Coincidence: press detected in same cycle as ms_tick with counter=99 -> react_time=99. Held btn across a second sequence gives no result until it is released and pressed again.
- Async reset asserted mid-TIMING (counter=40) -> all outputs 0 immediately. After release, state IDLE, waits for lights=8'h01.
- With F1_REACT_BEST_EN: results 300, 180, timeout, 250 -> best_time sequence 9999 -> 300 -> 180 -> 180 -> 180.

Source files
------------

// File: rtl/f1_react_pkg.sv
// Shared types and light-pattern constants for the F1 reaction timer.
package f1_react_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_OUT,
    TIMING,
    DONE,
    FOUL
  } state_t;

  localparam logic [7:0] LIGHTS_FIRST = 8'h01;
  localparam logic [7:0] LIGHTS_ALL   = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF   = 8'h00;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for the raw driver button plus a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is only a history flop; a held button gives a single pulse.
  assign press = s2 & ~s3;

endmodule

// File: rtl/f1_reaction_timer.sv
// Measures driver reaction from lights-out to button press, flags jump starts.
// Optional best-time tracking is enabled with `define F1_REACT_BEST_EN.
//
// state    | meaning
// IDLE     | waiting for first light (8'h01)
// ARMED    | light sequence building; press here is a jump start
// WAIT_OUT | all lights on; waiting for lights out
// TIMING   | counting ms ticks until press or MAX_MS
// DONE     | result published and held
// FOUL     | jump start detected; held until next sequence
module f1_reaction_timer
  import f1_react_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_MS    = 9999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           lights,
  input  logic                 ms_tick,
  input  logic                 btn,
  output logic [CNT_WIDTH-1:0] react_time,
  output logic                 valid,
  output logic                 jump_start,
  output logic                 timeout,
  output logic                 busy
`ifdef F1_REACT_BEST_EN
  ,
  output logic [CNT_WIDTH-1:0] best_time
`endif
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_MS);

  generate
    if (MAX_MS < 1 || longint'(MAX_MS) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_max
      $error("MAX_MS does not fit in CNT_WIDTH bits");
    end
  endgenerate

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt, rt_nxt;
  logic                   to_nxt, valid_nxt;
  logic                   press;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      react_time <= '0;
      timeout    <= 1'b0;
      valid      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      react_time <= rt_nxt;
      timeout    <= to_nxt;
      valid      <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rt_nxt    = react_time;
    to_nxt    = timeout;
    valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (lights == LIGHTS_FIRST) state_nxt = ARMED;
      end
      ARMED: begin
        if (press)                     state_nxt = FOUL;
        else if (lights == LIGHTS_ALL) state_nxt = WAIT_OUT;
        else if (lights == LIGHTS_OFF) state_nxt = IDLE;
      end
      WAIT_OUT: begin
        // A press sampled together with lights out happened first: foul.
        if (press) begin
          state_nxt = FOUL;
        end else if (lights == LIGHTS_OFF) begin
          state_nxt = TIMING;
          cnt_nxt   = '0;
        end
      end
      TIMING: begin
        // Press wins over a coincident tick, so the result is the pre-tick count.
        if (press) begin
          state_nxt = DONE;
          rt_nxt    = cnt;
          to_nxt    = 1'b0;
          valid_nxt = 1'b1;
        end else if (cnt == MAX_CNT) begin
          state_nxt = DONE;
          rt_nxt    = MAX_CNT;
          to_nxt    = 1'b1;
          valid_nxt = 1'b1;
        end else if (ms_tick) begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      DONE, FOUL: begin
        if (lights == LIGHTS_FIRST) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign jump_start = (state == FOUL);
  assign busy       = (state == ARMED) || (state == WAIT_OUT) || (state == TIMING);

`ifdef F1_REACT_BEST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_time <= MAX_CNT;
    end else if (valid_nxt && !to_nxt && (rt_nxt < best_time)) begin
      best_time <= rt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Self-checking bench for f1_reaction_timer: scenario table plus randomized runs.
module tb_f1_reaction_timer;

  localparam int CW    = 16;
  localparam int MAXMS = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    lights;
  logic          ms_tick;
  logic          btn;
  logic [CW-1:0] react_time;
  logic          valid, jump_start, timeout, busy;
`ifdef F1_REACT_BEST_EN
  logic [CW-1:0] best_time;
`endif

  f1_reaction_timer #(.CNT_WIDTH(CW), .MAX_MS(MAXMS)) dut (
    .clk        (clk),
    .rst        (rst),
    .lights     (lights),
    .ms_tick    (ms_tick),
    .btn        (btn),
    .react_time (react_time),
    .valid      (valid),
    .jump_start (jump_start),
    .timeout    (timeout),
    .busy       (busy)
`ifdef F1_REACT_BEST_EN
    ,
    .best_time  (best_time)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int vcnt   = 0;
  int model_rt = 0;
  int model_to = 0;
  int best_exp = MAXMS;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_lights(input int jump_idx);
    for (int i = 0; i < 8; i++) begin
      logic [8:0] p;
      p = 9'((1 << (i + 1)) - 1);
      lights = p[7:0];
      if (i == jump_idx) btn = 1'b1;
      step(4);
    end
    lights = 8'h00;
    step(2);
  endtask

  // Reference rules: result is the tick count before the press, capped at MAX_MS
  // (cap reached means timeout); a jump start leaves the last result untouched.
  task automatic run_seq(input int ticks, input int jump_idx, input bit coincide,
                         input string tag);
    int exp_v, exp_rt, exp_to, exp_js;
    vcnt = 0;
    lights = 8'h01;
    step(1);
    chk({tag, " busy_armed"}, int'(busy), 1);
    do_lights(jump_idx);
    if (jump_idx < 0) begin
      for (int k = 0; k < ticks; k++) begin
        step($urandom_range(0, 2));
        ms_tick = 1'b1;
        step(1);
        ms_tick = 1'b0;
      end
      btn = 1'b1;
      if (coincide) begin
        step(2);
        ms_tick = 1'b1;
        step(1);
        ms_tick = 1'b0;
      end else begin
        step(4);
      end
      step(3);
    end else begin
      step(4);
    end
    btn = 1'b0;
    step(2);
    if (jump_idx >= 0) begin
      exp_v = 0; exp_rt = model_rt; exp_to = model_to; exp_js = 1;
    end else begin
      exp_v  = 1;
      exp_rt = (ticks < MAXMS) ? ticks : MAXMS;
      exp_to = (ticks >= MAXMS) ? 1 : 0;
      exp_js = 0;
      if (exp_to == 0 && exp_rt < best_exp) best_exp = exp_rt;
    end
    model_rt = exp_rt;
    model_to = exp_to;
    chk({tag, " valid_pulses"}, vcnt, exp_v);
    chk({tag, " react_time"}, int'(react_time), exp_rt);
    chk({tag, " timeout"}, int'(timeout), exp_to);
    chk({tag, " jump_start"}, int'(jump_start), exp_js);
    chk({tag, " busy_end"}, int'(busy), 0);
`ifdef F1_REACT_BEST_EN
    chk({tag, " best_time"}, int'(best_time), best_exp);
`endif
  endtask

  typedef struct {
    int    ticks;
    int    jump_idx;
    bit    coincide;
    string tag;
  } scen_t;

  scen_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{300,      -1, 1'b0, "r300"};
    tbl[1] = '{180,      -1, 1'b0, "r180"};
    tbl[2] = '{MAXMS+5,  -1, 1'b0, "rto"};
    tbl[3] = '{250,      -1, 1'b0, "r250"};
    tbl[4] = '{237,      -1, 1'b0, "r237"};
    tbl[5] = '{99,       -1, 1'b1, "coin99"};
    tbl[6] = '{0,         3, 1'b0, "jump0F"};

    rst = 1'b1; lights = 8'h00; ms_tick = 1'b0; btn = 1'b0;
    step(3);
    chk("rst react_time", int'(react_time), 0);
    chk("rst valid", int'(valid), 0);
    chk("rst jump_start", int'(jump_start), 0);
    chk("rst timeout", int'(timeout), 0);
    chk("rst busy", int'(busy), 0);
`ifdef F1_REACT_BEST_EN
    chk("rst best_time", int'(best_time), MAXMS);
`endif
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 7; i++) run_seq(tbl[i].ticks, tbl[i].jump_idx, tbl[i].coincide, tbl[i].tag);

    // Next sequence after a foul clears jump_start and re-arms.
    lights = 8'h01;
    step(1);
    chk("rearm jump_start", int'(jump_start), 0);
    chk("rearm busy", int'(busy), 1);
    run_seq(12, -1, 1'b0, "after_foul");

    for (int r = 0; r < 8; r++) begin
      int n, j;
      n = $urandom_range(0, 450);
      j = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_seq(n, j, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    // Button pressed in DONE/FOUL and held through a whole new sequence.
    btn = 1'b1;
    step(4);
    vcnt = 0;
    lights = 8'h01;
    step(1);
    do_lights(-1);
    for (int k = 0; k < 20; k++) begin
      ms_tick = 1'b1; step(1); ms_tick = 1'b0; step(1);
    end
    step(5);
    chk("held no_valid", vcnt, 0);
    chk("held busy", int'(busy), 1);
    btn = 1'b0;
    step(3);
    btn = 1'b1;
    step(6);
    btn = 1'b0;
    chk("held repress valid", vcnt, 1);
    chk("held repress react_time", int'(react_time), 20);

    // Async reset in the middle of timing.
    lights = 8'h01;
    step(1);
    do_lights(-1);
    for (int k = 0; k < 40; k++) begin
      ms_tick = 1'b1; step(1); ms_tick = 1'b0;
    end
    vcnt = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst react_time", int'(react_time), 0);
    chk("midrst valid", int'(valid), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst timeout", int'(timeout), 0);
    chk("midrst jump_start", int'(jump_start), 0);
`ifdef F1_REACT_BEST_EN
    chk("midrst best_time", int'(best_time), MAXMS);
`endif
    step(2);
    rst = 1'b0;
    lights = 8'hFF;
    step(3);
    chk("postrst idle_ff", int'(busy), 0);
    lights = 8'h00;
    step(2);
    chk("postrst idle_00", int'(busy), 0);
    lights = 8'h01;
    step(1);
    chk("postrst armed", int'(busy), 1);
    chk("midrst no_valid", vcnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
